// File: rtl/m68k_irq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m68k_irq_ctrl_pkg                                                    |
// | Shared types, constants and helpers for the 68000 IRQ controller.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package m68k_irq_ctrl_pkg;

  typedef logic [2:0] irq_level_t;

  localparam logic [7:0] SPURIOUS_VEC = 8'h18;
  localparam logic [2:0] IACK_FC      = 3'b111;

  localparam int MAX_SRC = 16;
  localparam int IDX_W   = 4;
  localparam int LVL_W   = 3 * MAX_SRC;

  // Level table is widened to the maximum source count so one helper serves every size.
  function automatic irq_level_t lvl_of(input logic [LVL_W-1:0] levels, input int i);
    return levels[3*i +: 3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_prio_enc                                                         |
// | Highest eligible level, plus lowest-index eligible source at a level.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module irq_prio_enc
  import m68k_irq_ctrl_pkg::*;
#(
  parameter int                     NUM_SRC   = 4,
  parameter logic [3*NUM_SRC-1:0]   SRC_LEVEL = '0
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  irq_level_t         req_level,
  output irq_level_t         max_level,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [LVL_W-1:0] c_levels = LVL_W'(SRC_LEVEL);

  // Scan from the top down so the lowest matching index is the last to win.
  always_comb begin
    max_level = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i] && (lvl_of(c_levels, i) != 3'd0)) begin
        if (lvl_of(c_levels, i) > max_level) begin
          max_level = lvl_of(c_levels, i);
        end
        if (lvl_of(c_levels, i) == req_level) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/m68k_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m68k_irq_ctrl                                                        |
// | Parametrised 68000 interrupt controller: IPLn, VPAn and IACK vector. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module m68k_irq_ctrl
  import m68k_irq_ctrl_pkg::*;
#(
  parameter int                   NUM_SRC      = 4,
  parameter logic [3*NUM_SRC-1:0] SRC_LEVEL    = '0,
  parameter logic [NUM_SRC-1:0]   EDGE_MODE    = '1,
  parameter logic [NUM_SRC-1:0]   AUTOVEC      = '1,
  parameter logic [7:0]           VEC_BASE     = 8'h40,
  parameter logic [NUM_SRC-1:0]   ENABLE_RESET = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [2:0]         cpu_fc,
  input  logic [2:0]         cpu_addr,
  input  logic               cpu_as_n,
  input  logic               en_we,
  input  logic [NUM_SRC-1:0] en_din,
  output logic [NUM_SRC-1:0] enable,
  output logic [NUM_SRC-1:0] pending,
  output logic [2:0]         ipl_n,
  output logic               vpa_n,
  output logic               vec_valid,
  output logic [7:0]         vec
);

  localparam logic [LVL_W-1:0] c_levels = LVL_W'(SRC_LEVEL);

  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic               r_iack_prev;
  irq_level_t         r_ipl_n;
  logic               r_vpa_n;
  logic               r_vec_valid;
  logic [7:0]         r_vec;

  logic [NUM_SRC-1:0] w_lvl_nz;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_iack;
  logic               w_ack;
  logic               w_win_av;
  irq_level_t         w_max_level;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;

  assign w_iack     = (cpu_fc == IACK_FC) & ~cpu_as_n;
  assign w_ack      = w_iack & ~r_iack_prev;
  assign w_eligible = r_pending & r_enable & w_lvl_nz;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_lvl_nz[gi] = (lvl_of(c_levels, gi) != 3'd0);
      assign w_set[gi]    = EDGE_MODE[gi] ? (src[gi] & ~r_src_prev[gi]) : src[gi];
      assign w_win_oh[gi] = (w_win == IDX_W'(gi));
    end
  endgenerate

  assign w_clr    = w_win_oh & {NUM_SRC{w_ack & w_found}};
  assign w_win_av = |(AUTOVEC & w_win_oh);

  irq_prio_enc #(
    .NUM_SRC   (NUM_SRC),
    .SRC_LEVEL (SRC_LEVEL)
  ) u_prio_enc (
    .eligible  (w_eligible),
    .req_level (cpu_addr),
    .max_level (w_max_level),
    .found     (w_found),
    .idx       (w_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_prev  <= '0;
      r_pending   <= '0;
      r_enable    <= ENABLE_RESET;
      r_iack_prev <= 1'b0;
      r_ipl_n     <= 3'b111;
      r_vpa_n     <= 1'b1;
      r_vec_valid <= 1'b0;
      r_vec       <= 8'h00;
    end else begin
      r_src_prev  <= src;
      r_iack_prev <= w_iack;
      // Set after clear: a fresh request landing with its own acknowledge is kept.
      r_pending   <= (r_pending & ~w_clr) | w_set;
      if (en_we) begin
        r_enable <= en_din;
      end
      r_ipl_n <= ~w_max_level;
      if (w_ack) begin
        if (w_found && w_win_av) begin
          r_vpa_n     <= 1'b0;
          r_vec_valid <= 1'b0;
          r_vec       <= 8'h00;
        end else if (w_found) begin
          r_vpa_n     <= 1'b1;
          r_vec_valid <= 1'b1;
          r_vec       <= VEC_BASE + 8'(w_win);
        end else begin
          r_vpa_n     <= 1'b1;
          r_vec_valid <= 1'b1;
          r_vec       <= SPURIOUS_VEC;
        end
      end else if (cpu_as_n) begin
        r_vpa_n     <= 1'b1;
        r_vec_valid <= 1'b0;
        r_vec       <= 8'h00;
      end
    end
  end

  assign enable    = r_enable;
  assign pending   = r_pending;
  assign ipl_n     = r_ipl_n;
  assign vpa_n     = r_vpa_n;
  assign vec_valid = r_vec_valid;
  assign vec       = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_m68k_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_m68k_irq_ctrl                                                     |
// | Directed and randomized bench with an in-bench reference model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_m68k_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] src;
  logic [2:0] cpu_fc;
  logic [2:0] cpu_addr;
  logic       cpu_as_n;
  logic       en_we;
  logic [3:0] en_din;
  logic [3:0] enable;
  logic [3:0] pending;
  logic [2:0] ipl_n;
  logic       vpa_n;
  logic       vec_valid;
  logic [7:0] vec;

  // Source table: levels 5,6,4,0; source 2 is level-sensitive and vectored.
  int lv_tab   [4] = '{5, 6, 4, 0};
  bit edge_tab [4] = '{1, 1, 0, 1};
  bit av_tab   [4] = '{1, 1, 0, 1};

  m68k_irq_ctrl #(
    .NUM_SRC      (4),
    .SRC_LEVEL    ({3'd0, 3'd4, 3'd6, 3'd5}),
    .EDGE_MODE    (4'b1011),
    .AUTOVEC      (4'b1011),
    .VEC_BASE     (8'h40),
    .ENABLE_RESET (4'b1111)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .cpu_fc    (cpu_fc),
    .cpu_addr  (cpu_addr),
    .cpu_as_n  (cpu_as_n),
    .en_we     (en_we),
    .en_din    (en_din),
    .enable    (enable),
    .pending   (pending),
    .ipl_n     (ipl_n),
    .vpa_n     (vpa_n),
    .vec_valid (vec_valid),
    .vec       (vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  logic [3:0] m_pend, m_prev, m_en;
  bit         m_iack_prev;
  int         m_ipl_n;
  bit         m_vpa_n, m_vv;
  int         m_vec;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_update();
    int best;
    int win;
    bit ack;
    logic [3:0] np;
    if (reset) begin
      m_pend = '0; m_prev = '0; m_en = 4'hF; m_iack_prev = 0;
      m_ipl_n = 7; m_vpa_n = 1; m_vv = 0; m_vec = 0;
      return;
    end
    best = 0;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && m_en[i] && lv_tab[i] > best) best = lv_tab[i];
    ack = (cpu_fc == 3'b111) && !cpu_as_n && !m_iack_prev;
    win = -1;
    if (ack)
      for (int i = 0; i < 4; i++)
        if (win < 0 && m_pend[i] && m_en[i] && lv_tab[i] != 0 && lv_tab[i] == int'(cpu_addr))
          win = i;
    np = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (i == win) np[i] = 1'b0;
      if (edge_tab[i] ? (src[i] && !m_prev[i]) : src[i]) np[i] = 1'b1;
    end
    if (ack) begin
      if (win >= 0 && av_tab[win]) begin
        m_vpa_n = 0; m_vv = 0; m_vec = 0;
      end else begin
        m_vpa_n = 1; m_vv = 1; m_vec = (win >= 0) ? (64 + win) % 256 : 24;
      end
    end else if (cpu_as_n) begin
      m_vpa_n = 1; m_vv = 0; m_vec = 0;
    end
    m_ipl_n = 7 - best;
    m_pend  = np;
    if (en_we) m_en = en_din;
    m_prev      = src;
    m_iack_prev = (cpu_fc == 3'b111) && !cpu_as_n;
  endfunction

  task automatic model_compare();
    check("ipl_n",     32'(ipl_n),     m_ipl_n);
    check("vpa_n",     32'(vpa_n),     32'(m_vpa_n));
    check("vec_valid", 32'(vec_valid), 32'(m_vv));
    check("vec",       32'(vec),       m_vec);
    check("pending",   32'(pending),   32'(m_pend));
    check("enable",    32'(enable),    32'(m_en));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (chk_on) model_compare();
  endtask

  task automatic iack_begin(input logic [2:0] lvl);
    cpu_fc = 3'b111; cpu_addr = lvl; cpu_as_n = 1'b0;
  endtask

  task automatic iack_end();
    cpu_as_n = 1'b1; cpu_fc = 3'b000;
  endtask

  int bus_left  = 0;
  int idle_left = 0;

  initial begin
    reset = 1'b1; src = '0; cpu_fc = '0; cpu_addr = '0; cpu_as_n = 1'b1;
    en_we = 1'b0; en_din = '0;
    step(); step();
    chk_on = 1;
    check("rst_pending", 32'(pending), 0);
    check("rst_enable", 32'(enable), 15);
    check("rst_ipl_n", 32'(ipl_n), 7);
    check("rst_vpa_n", 32'(vpa_n), 1);
    check("rst_vec_valid", 32'(vec_valid), 0);
    check("rst_vec", 32'(vec), 0);
    reset = 1'b0;

    // Single edge source, autovector acknowledge.
    src = 4'b0001; step(); src = '0;
    check("edge_pending", 32'(pending), 1);
    check("edge_ipl_lat", 32'(ipl_n), 7);
    step();
    check("edge_ipl", 32'(ipl_n), 2);
    check("model_ipl", m_ipl_n, 2);
    iack_begin(3'd5); step();
    check("ack5_pending", 32'(pending), 0);
    check("ack5_vpa_n", 32'(vpa_n), 0);
    step();
    check("ack5_ipl", 32'(ipl_n), 7);
    check("ack5_vpa_hold", 32'(vpa_n), 0);
    iack_end(); step();
    check("ack5_vpa_rel", 32'(vpa_n), 1);

    // Two levels pending: the higher is presented first.
    src = 4'b0011; step(); src = '0; step();
    check("prio_ipl", 32'(ipl_n), 1);
    iack_begin(3'd6); step();
    check("prio_pending", 32'(pending), 1);
    step();
    check("prio_ipl_after", 32'(ipl_n), 2);
    iack_end(); step();
    iack_begin(3'd5); step(); iack_end(); step();
    check("prio_ipl_clear", 32'(ipl_n), 7);
    check("prio_pending0", 32'(pending), 0);

    // Vectored, level-sensitive source.
    src = 4'b0100; step(); src = '0;
    check("vec_pending", 32'(pending), 4);
    step();
    check("vec_ipl", 32'(ipl_n), 3);
    iack_begin(3'd4); step();
    check("vec_valid", 32'(vec_valid), 1);
    check("vec_value", 32'(vec), 32'h42);
    check("vec_vpa_n", 32'(vpa_n), 1);
    check("vec_pending0", 32'(pending), 0);
    iack_end(); step();
    check("vec_valid_rel", 32'(vec_valid), 0);
    check("vec_rel", 32'(vec), 0);

    // Spurious acknowledge.
    iack_begin(3'd3); step();
    check("spur_valid", 32'(vec_valid), 1);
    check("spur_vec", 32'(vec), 32'h18);
    check("spur_pending", 32'(pending), 0);
    iack_end(); step();

    // Level-0 source latches but is never presented nor acknowledged.
    src = 4'b1000; step(); src = '0;
    check("lvl0_pending", 32'(pending), 8);
    step(); step();
    check("lvl0_ipl", 32'(ipl_n), 7);
    iack_begin(3'd0); step();
    check("lvl0_spur_vec", 32'(vec), 32'h18);
    check("lvl0_pending_kept", 32'(pending), 8);
    iack_end(); step();

    // Disabled source stays pending but hidden until re-enabled.
    en_we = 1'b1; en_din = 4'b0000; step(); en_we = 1'b0;
    check("dis_enable", 32'(enable), 0);
    src = 4'b0001; step(); src = '0; step(); step();
    check("dis_pending", 32'(pending), 9);
    check("dis_ipl", 32'(ipl_n), 7);
    en_we = 1'b1; en_din = 4'b0001; step(); en_we = 1'b0;
    check("reen_enable", 32'(enable), 1);
    step();
    check("reen_ipl", 32'(ipl_n), 2);

    // New edge coincides with its own acknowledge: stays pending.
    src = 4'b0001; iack_begin(3'd5); step();
    check("coinc_pending", 32'(pending), 9);
    check("coinc_vpa_n", 32'(vpa_n), 0);
    src = '0; iack_end(); step(); step();
    check("coinc_ipl", 32'(ipl_n), 2);

    // Reset in the middle of an acknowledge.
    iack_begin(3'd5); step();
    check("rstiack_vpa0", 32'(vpa_n), 0);
    reset = 1'b1; step();
    check("rstiack_ipl", 32'(ipl_n), 7);
    check("rstiack_vpa", 32'(vpa_n), 1);
    check("rstiack_pending", 32'(pending), 0);
    check("rstiack_enable", 32'(enable), 15);
    reset = 1'b0; iack_end(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset  = ($urandom_range(0, 599) == 0);
      src    = 4'($urandom & $urandom);
      en_we  = ($urandom_range(0, 11) == 0);
      en_din = 4'($urandom | $urandom);
      if (!cpu_as_n) begin
        if (bus_left == 0) begin
          cpu_as_n  = 1'b1;
          idle_left = int'($urandom_range(0, 3));
        end else begin
          bus_left--;
        end
      end else if (idle_left > 0) begin
        idle_left--;
      end else begin
        cpu_fc   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        cpu_addr = 3'($urandom);
        cpu_as_n = 1'b0;
        bus_left = int'($urandom_range(0, 3));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
